// File: rtl/ibex_rf_l2_responder.sv
// Register-file backing store for an L1 fill path: single-port array with a write-through FIFO buffer.
// Define IBEX_RF_L2_FWD_EN to let reads forward from the write buffer instead of waiting for drains.
module ibex_rf_l2_responder #(
  parameter bit          RV32E      = 1'b0,
  parameter int unsigned DataWidth  = 32,
  parameter int unsigned WrBufDepth = 2
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 rd_req_i,
  input  logic [4:0]           rd_addr_i,
  output logic                 rd_gnt_o,
  output logic                 rd_rvalid_o,
  output logic [DataWidth-1:0] rd_rdata_o,
  output logic                 rd_err_o,
  input  logic                 wr_req_i,
  input  logic [4:0]           wr_addr_i,
  input  logic [DataWidth-1:0] wr_data_i,
  output logic                 wr_gnt_o,
  output logic                 busy_o
);

  localparam int unsigned NumWords = RV32E ? 16 : 32;
  localparam int unsigned AW       = RV32E ? 4 : 5;
  localparam int unsigned PW       = (WrBufDepth > 1) ? $clog2(WrBufDepth) : 1;
  localparam int unsigned CW       = $clog2(WrBufDepth + 1);

`ifdef IBEX_RF_L2_FWD_EN
  localparam bit FwdEn = 1'b1;
`else
  localparam bit FwdEn = 1'b0;
`endif

  typedef enum logic {INIT, READY} state_e;

  state_e               state_q, state_d;
  logic [AW-1:0]        init_cnt_q, init_cnt_d;
  logic [DataWidth-1:0] mem_q [NumWords];
  logic [DataWidth-1:0] mem_d [NumWords];
  logic [4:0]           buf_addr_q [WrBufDepth];
  logic [4:0]           buf_addr_d [WrBufDepth];
  logic [DataWidth-1:0] buf_data_q [WrBufDepth];
  logic [DataWidth-1:0] buf_data_d [WrBufDepth];
  logic [PW-1:0]        rptr_q, rptr_d, wptr_q, wptr_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic                 rvalid_q, rvalid_d;
  logic [DataWidth-1:0] rdata_q, rdata_d;
  logic                 err_q, err_d;

  logic                 is_ready, buf_full, buf_empty;
  logic                 rd_zero, rd_illegal, wr_drop;
  logic                 fwd_hit, rd_gnt, wr_gnt, drain, push;
  logic [DataWidth-1:0] fwd_data, rd_value;

  function automatic logic [PW-1:0] ptr_off(input logic [PW-1:0] p, input int unsigned off);
    int unsigned s;
    s = 32'(p) + off;
    if (s >= WrBufDepth) s = s - WrBufDepth;
    return PW'(s);
  endfunction

  // Youngest matching buffer entry wins, so scan oldest to youngest and keep the last hit.
  always_comb begin
    fwd_hit  = 1'b0;
    fwd_data = '0;
    for (int unsigned i = 0; i < WrBufDepth; i++) begin
      if (i < 32'(cnt_q) && buf_addr_q[ptr_off(rptr_q, i)] == rd_addr_i) begin
        fwd_hit  = 1'b1;
        fwd_data = buf_data_q[ptr_off(rptr_q, i)];
      end
    end
  end

  assign is_ready   = (state_q == READY);
  assign buf_full   = (cnt_q == CW'(WrBufDepth));
  assign buf_empty  = (cnt_q == '0);
  assign rd_zero    = (rd_addr_i == 5'd0);
  assign rd_illegal = RV32E && rd_addr_i[4];
  assign wr_drop    = (wr_addr_i == 5'd0) || (RV32E && wr_addr_i[4]);

  // A full buffer steals the port from reads; without forwarding, reads also stall on a pending match.
  assign rd_gnt = is_ready && rd_req_i && !buf_full && (FwdEn || !fwd_hit);
  assign drain  = is_ready && !buf_empty && !rd_gnt;
  assign wr_gnt = wr_req_i && is_ready && (!buf_full || drain);
  assign push   = wr_gnt && !wr_drop;

  always_comb begin
    rd_value = '0;
    if (!rd_zero && !rd_illegal) begin
      if (FwdEn && fwd_hit) rd_value = fwd_data;
      else                  rd_value = mem_q[rd_addr_i[AW-1:0]];
    end
  end

  always_comb begin
    state_d    = state_q;
    init_cnt_d = init_cnt_q;
    mem_d      = mem_q;
    buf_addr_d = buf_addr_q;
    buf_data_d = buf_data_q;
    rptr_d     = rptr_q;
    wptr_d     = wptr_q;
    cnt_d      = cnt_q;
    rvalid_d   = rd_gnt;
    rdata_d    = rd_gnt ? rd_value : '0;
    err_d      = rd_gnt && rd_illegal;

    if (state_q == INIT) begin
      mem_d[init_cnt_q] = '0;
      init_cnt_d        = init_cnt_q + 1'b1;
      if (init_cnt_q == AW'(NumWords - 1)) state_d = READY;
    end

    if (drain) begin
      mem_d[buf_addr_q[rptr_q][AW-1:0]] = buf_data_q[rptr_q];
      rptr_d = ptr_off(rptr_q, 1);
    end

    if (push) begin
      buf_addr_d[wptr_q] = wr_addr_i;
      buf_data_d[wptr_q] = wr_data_i;
      wptr_d = ptr_off(wptr_q, 1);
    end

    case ({push, drain})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= INIT;
      init_cnt_q <= '0;
      rptr_q     <= '0;
      wptr_q     <= '0;
      cnt_q      <= '0;
      rvalid_q   <= 1'b0;
      rdata_q    <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      init_cnt_q <= init_cnt_d;
      rptr_q     <= rptr_d;
      wptr_q     <= wptr_d;
      cnt_q      <= cnt_d;
      rvalid_q   <= rvalid_d;
      rdata_q    <= rdata_d;
      err_q      <= err_d;
    end
  end

  // Storage is cleared by the INIT sweep rather than by reset.
  always_ff @(posedge clk_i) begin
    mem_q      <= mem_d;
    buf_addr_q <= buf_addr_d;
    buf_data_q <= buf_data_d;
  end

  assign rd_gnt_o    = rd_gnt;
  assign wr_gnt_o    = wr_gnt;
  assign rd_rvalid_o = rvalid_q;
  assign rd_rdata_o  = rdata_q;
  assign rd_err_o    = err_q;
  assign busy_o      = !is_ready || !buf_empty;

endmodule
